// File: rtl/instr_fetcher.sv
// instr_fetcher
//   Front-end fetch stage feeding the decoder. It holds the PC, looks it up in
//   a direct-mapped instruction cache (one 32-bit word per entry) and, on a
//   miss, reads a single word from the memory controller. It presents one
//   instruction at a time. The next PC comes from the decoder's prediction,
//   and a RoB flush redirects the PC to the corrected PC.
//
// Parameters
//   ICACHE_IDX_WIDTH  log2 of the cache entry count
//   RESET_PC          PC loaded at reset
//
// Ports
//   clk_i               system clock
//   rst_i               synchronous, active-high reset (wins over rdy_i)
//   rdy_i               global enable; when low, no register changes
//   rob_clear_i         flush pulse from the RoB
//   rob_clear_pc_i      corrected PC, valid with rob_clear_i
//   mem_req_o           instruction-word read request
//   mem_addr_o          word address of the request ([1:0] = 0)
//   mem_done_i          one-cycle pulse: mem_data_i is valid
//   mem_data_i          returned instruction word
//   dec_stall_i         decoder cannot accept this cycle
//   instr_issued_i      decoder issued the last instruction; predict_pc_i valid
//   predict_pc_i        next PC from the decoder
//   instr_ready_o       instr_out_o / instr_addr_out_o are valid
//   instr_out_o         instruction word
//   instr_addr_out_o    PC of instr_out_o
//
// States
//   S_LOOKUP  | probe the cache with pc_q; hit -> present, miss -> request
//   S_MISS    | request outstanding; the returned word is presented
//   S_HOLD    | instruction presented; waiting for the decoder to take it
//   S_WAIT_PC | instruction consumed; waiting for the predicted PC
//   S_DRAIN   | flushed while a request was outstanding; fill, do not present

module instr_fetcher #(
    parameter int          ICACHE_IDX_WIDTH = 6,
    parameter logic [31:0] RESET_PC         = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rdy_i,
    input  logic        rob_clear_i,
    input  logic [31:0] rob_clear_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_data_i,
    input  logic        dec_stall_i,
    input  logic        instr_issued_i,
    input  logic [31:0] predict_pc_i,
    output logic        instr_ready_o,
    output logic [31:0] instr_out_o,
    output logic [31:0] instr_addr_out_o
);

    localparam int IW = ICACHE_IDX_WIDTH;
    localparam int NE = 1 << IW;
    localparam int TW = 32 - IW - 2;

    typedef enum logic [2:0] {
        S_LOOKUP,
        S_MISS,
        S_HOLD,
        S_WAIT_PC,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic            ready_q, ready_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     iaddr_q, iaddr_d;

    logic [NE-1:0]   valid_q;
    logic [TW-1:0]   tag_q  [NE];
    logic [31:0]     data_q [NE];

    logic [IW-1:0]   pc_idx;
    logic [TW-1:0]   pc_tag;
    logic            hit;
    logic            fill_en;
    logic [IW-1:0]   fill_idx;
    logic [TW-1:0]   fill_tag;

    assign pc_idx = pc_q[IW+1:2];
    assign pc_tag = pc_q[31:IW+2];
    assign hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    // Fills are addressed from the latched request address, not the PC: after
    // a flush the PC already points elsewhere while the old word is returning.
    assign fill_idx = mem_addr_q[IW+1:2];
    assign fill_tag = mem_addr_q[31:IW+2];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ready_d    = ready_q;
        instr_d    = instr_q;
        iaddr_d    = iaddr_q;
        fill_en    = 1'b0;

        unique case (state_q)
            S_LOOKUP: begin
                if (hit) begin
                    instr_d = data_q[pc_idx];
                    iaddr_d = pc_q;
                    ready_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_q[31:2], 2'b00};
                    state_d    = S_MISS;
                end
            end
            S_MISS: begin
                if (mem_done_i) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    instr_d   = mem_data_i;
                    iaddr_d   = pc_q;
                    ready_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ready_q && !dec_stall_i) begin
                    ready_d = 1'b0;
                    state_d = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (instr_issued_i) begin
                    pc_d    = predict_pc_i;
                    state_d = S_LOOKUP;
                end
            end
            S_DRAIN: begin
                if (mem_done_i) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_LOOKUP;
                end
            end
            default: state_d = S_LOOKUP;
        endcase

        // Flush overrides whatever the state decided. The presented word and
        // its address simply hold; only instr_ready drops. A flush while a
        // request is outstanding (MISS, or a repeated flush in DRAIN) must
        // still retire that request before a new one can be issued.
        if (rob_clear_i) begin
            pc_d    = rob_clear_pc_i;
            ready_d = 1'b0;
            instr_d = instr_q;
            iaddr_d = iaddr_q;
            if (state_q == S_MISS || state_q == S_DRAIN) begin
                mem_addr_d = mem_addr_q;
                if (mem_done_i) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_LOOKUP;
                end else begin
                    mem_req_d = 1'b1;
                    state_d   = S_DRAIN;
                end
            end else begin
                mem_req_d  = mem_req_q;
                mem_addr_d = mem_addr_q;
                state_d    = S_LOOKUP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_LOOKUP;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            ready_q    <= 1'b0;
            instr_q    <= 32'h0;
            iaddr_q    <= 32'h0;
            valid_q    <= '0;
        end else if (rdy_i) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ready_q    <= ready_d;
            instr_q    <= instr_d;
            iaddr_q    <= iaddr_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset: entries are only read behind valid_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && rdy_i && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data_i;
        end
    end

    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = mem_addr_q;
    assign instr_ready_o    = ready_q;
    assign instr_out_o      = instr_q;
    assign instr_addr_out_o = iaddr_q;

endmodule
